clkdiv_multi: RTL

Multi-channel, runtime-programmable clock divider that steps the 50 MHz board clock down to several independent slow square waves. Each channel has its own loadable half-period and enable, and emits a single-cycle rising-edge tick for logic that stays on `iclk`. Sits at the top level next to the game FSM and drives LED blink, debounce sampling and display refresh rates from one block.

---
 rtl/clkdiv_multi.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clkdiv_multi.sv
// clkdiv_multi
// Multi-channel, runtime-programmable clock divider. Steps the board clock
// down to CHANNELS independent square waves. Each channel has its own
// loadable half-period and run enable. Each channel also emits a one-cycle
// tick for logic that stays in the iclk domain.
//
// Optional feature macro: CLKDIV_SYNC_EN. When it is defined, the sync input
// is added. Holding sync high restarts every channel phase-aligned.
//
// Parameters
//   CHANNELS      number of divider channels (1..16)
//   CW            counter / half-period width
//   DEFAULT_HALF  half-period loaded into every channel at reset
//
// Ports
//   iclk     in   system clock, all state registered on its rising edge
//   rst      in   synchronous active-high reset
//   en       in   per-channel run enable; low freezes the channel
//   wr_en    in   single-cycle write strobe for a new half-period
//   wr_chan  in   target channel of the write
//   wr_half  in   new half-period in iclk cycles (0 is rejected)
//   sync     in   (CLKDIV_SYNC_EN only) restart all channels
//   wr_err   out  one-cycle pulse, the cycle after a rejected write
//   oclk     out  divided square waves, registered
//   tick     out  high in exactly the cycle the matching oclk bit becomes 1
module clkdiv_multi #(
  parameter int CHANNELS     = 4,
  parameter int CW           = 32,
  parameter int DEFAULT_HALF = 12500000,
  localparam int WCW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                iclk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                wr_en,
  input  logic [WCW-1:0]      wr_chan,
  input  logic [CW-1:0]       wr_half,
`ifdef CLKDIV_SYNC_EN
  input  logic                sync,
`endif
  output logic                wr_err,
  output logic [CHANNELS-1:0] oclk,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [CW-1:0] RESET_HALF = CW'(DEFAULT_HALF);
  localparam logic [31:0]   NCH        = 32'(CHANNELS);

  logic [31:0] chan_ext;
  logic        wr_ok;
  logic        wr_bad;

  // The channel field can encode codes beyond CHANNELS when CHANNELS is not
  // a power of two. Those codes, and a zero half-period, are rejected.
  assign chan_ext = 32'(wr_chan);
  assign wr_ok    = wr_en && (wr_half != '0) && (chan_ext < NCH);
  assign wr_bad   = wr_en && !((wr_half != '0) && (chan_ext < NCH));

  // Rejection flag. It is registered, so it pulses one cycle after the bad strobe.
  always_ff @(posedge iclk) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_bad;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [CW-1:0] count;
    logic [CW-1:0] active_half;
    logic [CW-1:0] shadow_half;
    logic          oclk_q;
    logic          tick_q;
    logic          hit;
    logic          boundary;

    assign hit      = wr_ok && (chan_ext == 32'(g));
    assign boundary = (count == active_half - CW'(1));
    assign oclk[g]  = oclk_q;
    assign tick[g]  = tick_q;

    // Per-channel divider. A write to a running channel only updates the
    // shadow copy, so the half-period in flight is never cut short. The
    // exception is a write that lands on the boundary itself: that write is
    // forwarded straight into active_half. A write to a stopped channel
    // takes effect at once and rewinds the count. Re-enabling the channel
    // then gives a full new half-period before the first toggle.
    always_ff @(posedge iclk) begin
      if (rst) begin
        count       <= '0;
        active_half <= RESET_HALF;
        shadow_half <= RESET_HALF;
        oclk_q      <= 1'b0;
        tick_q      <= 1'b0;
      end
`ifdef CLKDIV_SYNC_EN
      else if (sync) begin
        count       <= '0;
        oclk_q      <= 1'b0;
        tick_q      <= 1'b0;
        active_half <= shadow_half;
      end
`endif
      else begin
        tick_q <= 1'b0;
        if (hit && !en[g]) begin
          active_half <= wr_half;
          shadow_half <= wr_half;
          count       <= '0;
        end else begin
          if (hit) begin
            shadow_half <= wr_half;
          end
          if (en[g]) begin
            if (boundary) begin
              count       <= '0;
              oclk_q      <= ~oclk_q;
              tick_q      <= ~oclk_q;
              active_half <= hit ? wr_half : shadow_half;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
      end
    end
  end

endmodule
